pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage, directly upstream of the jump control block.
- Consumes its redirect outputs (jmp_loc, pc_mux_sel).
- Produces the registered instruction word and its address (ins, Current_Address) that the jump block and decode consume.
- Fetches from instruction memory over a variable-latency req/ack handshake. Supports pipeline stall and squash-on-redirect.

Parameters:
RESET_VECTOR, 8'h00, PC value loaded on reset
NOP_WORD, 24'h000000, instruction word driven when no valid instruction

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
jmp_loc  input  8  redirect target from jump control block
pc_mux_sel  input  1  1 = redirect PC to jmp_loc this cycle
stall  input  1  1 = downstream cannot accept a new instruction
imem_req  output  1  fetch request to instruction memory
imem_addr  output  8  fetch address; equals PC
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  24  fetched instruction word
ins  output  24  registered instruction to downstream
Current_Address  output  8  address of ins
ins_valid  output  1  ins holds a real instruction

Behaviour:
- Reset (reset=0, asynchronous) forces the following values:
  - pc = RESET_VECTOR; state = IDLE; imem_req = 0; imem_addr = RESET_VECTOR.
  - ins = NOP_WORD; Current_Address = RESET_VECTOR; ins_valid = 0.
  - redirect_pending = 0; skid register cleared.
- Reset asserted mid-operation aborts any outstanding request. Memory must tolerate the dropped request.
- imem_req = (state==REQ) and imem_addr = pc, both combinational from registers.
- imem_addr is stable while imem_req=1 and no ack.
- PC increment is 8-bit: 8'hFF + 1 wraps to 8'h00.
- IDLE: always moves to REQ on the next clock. The first request is visible one cycle after reset release.
- REQ, imem_ack=0, pc_mux_sel=1:
  - Set redirect_pending and capture redir_addr <= jmp_loc. A later redirect overwrites it (latest wins).
  - pc is unchanged, so the address stays stable.
- REQ, imem_ack=1, with pc_mux_sel=1 or redirect_pending=1:
  - Discard imem_rdata.
  - pc <= jmp_loc if pc_mux_sel, else redir_addr. The current-cycle redirect has priority.
  - Clear pending and stay in REQ, so the new address is requested the next cycle.
- REQ, imem_ack=1, no redirect, stall=0:
  - ins <= imem_rdata; Current_Address <= pc; ins_valid <= 1; pc <= pc+1.
  - Stay in REQ.
  - Back-to-back acks give one instruction per clock.
- REQ, imem_ack=1, no redirect, stall=1:
  - skid_ins <= imem_rdata; skid_addr <= pc; pc <= pc+1.
  - Go to FULL, which drops imem_req.
- FULL, pc_mux_sel=1: drop the skid entry, pc <= jmp_loc, go to REQ.
- FULL, stall=0, no redirect: ins <= skid_ins; Current_Address <= skid_addr; ins_valid <= 1; go to REQ.
- FULL, stall=1, no redirect: hold.
- Output register rules, in priority order:
  - pc_mux_sel=1 in any state: ins <= NOP_WORD, ins_valid <= 0, Current_Address held. Redirect beats stall.
  - Otherwise stall=1: ins, Current_Address and ins_valid are held.
  - Otherwise no instruction loaded this cycle: ins <= NOP_WORD, ins_valid <= 0.
- imem_ack while in IDLE or FULL is a protocol violation and is ignored; there is no state change.
- Latency: from ack to ins_valid is one clock. From pc_mux_sel to the request at jmp_loc is one clock when no fetch is outstanding, otherwise one clock after the outstanding ack.
- Recommended encoding is 2-bit: IDLE=0, REQ=1, FULL=2. State 3 recovers to IDLE.

Test Plan:
- Reset and linear fetch:
  - Stimulus: release reset, memory acks every cycle with rdata = {16'h0, addr}.
  - Required response: imem_addr 00,01,02…; ins = 24'h000000 then 24'h000001…; Current_Address trails imem_addr by 1; ins_valid=1 continuous.
- Wrap:
  - Stimulus: RESET_VECTOR=8'hFE, acks every cycle.
  - Required response: imem_addr FE, FF, 00, 01; no glitch on ins_valid.
- Redirect with nothing outstanding:
  - Stimulus: at Current_Address=8'h05 pulse pc_mux_sel=1 with jmp_loc=8'h40.
  - Required response: next cycle ins=24'h000000, ins_valid=0; next request imem_addr=8'h40; ins=24'h000040 valid after its ack.
- Redirect during an outstanding request:
  - Stimulus: memory latency 3 cycles; pulse pc_mux_sel at latency cycle 1 with jmp_loc=8'h20, and again at cycle 2 with 8'h30.
  - Required response: the returned word is discarded; the next request is to 8'h30; 8'h20 is never fetched.
- Stall with skid:
  - Stimulus: assert stall=1 for 4 cycles while an ack for addr 8'h10 arrives.
  - Required response: imem_req=0 after the ack; ins and Current_Address hold; on stall release ins=24'h000010, Current_Address=8'h10, then fetch resumes at 8'h11.
- Async reset mid-request:
  - Stimulus: drop reset between clock edges while imem_req=1 at addr 8'h33.
  - Required response: imem_req=0, ins_valid=0 and pc=RESET_VECTOR immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter / instruction-fetch stage: fetches from instruction memory over a
// variable-latency req/ack handshake, with a one-entry skid for stall and squash-on-redirect.
module pc_fetch_unit #(
  parameter logic [7:0]  RESET_VECTOR = 8'h00,
  parameter logic [23:0] NOP_WORD     = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  jmp_loc,
  input  logic        pc_mux_sel,
  input  logic        stall,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [23:0] imem_rdata,
  output logic [23:0] ins,
  output logic [7:0]  Current_Address,
  output logic        ins_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    RSVD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [23:0] ins_q, ins_d;
  logic [7:0]  cur_addr_q, cur_addr_d;
  logic        ins_valid_q, ins_valid_d;
  logic        redirect_pending_q, redirect_pending_d;
  logic [7:0]  redir_addr_q, redir_addr_d;
  logic [23:0] skid_ins_q, skid_ins_d;
  logic [7:0]  skid_addr_q, skid_addr_d;

  // Instruction handed to the output register this cycle, if any.
  logic        load;
  logic [23:0] load_ins;
  logic [7:0]  load_addr;

  assign imem_req        = (state_q == REQ);
  assign imem_addr       = pc_q;
  assign ins             = ins_q;
  assign Current_Address = cur_addr_q;
  assign ins_valid       = ins_valid_q;

  always_comb begin
    // NOTE: every _d starts as its _q (hold) so no path through this block infers a latch.
    state_d            = state_q;
    pc_d               = pc_q;
    redirect_pending_d = redirect_pending_q;
    redir_addr_d       = redir_addr_q;
    skid_ins_d         = skid_ins_q;
    skid_addr_d        = skid_addr_q;
    ins_d              = ins_q;
    cur_addr_d         = cur_addr_q;
    ins_valid_d        = ins_valid_q;
    load               = 1'b0;
    load_ins           = NOP_WORD;
    load_addr          = pc_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (pc_mux_sel) pc_d = jmp_loc;
      end

      REQ: begin
        if (imem_ack) begin
          if (pc_mux_sel || redirect_pending_q) begin
            // Returned word belongs to the squashed path; re-request at the target.
            pc_d               = pc_mux_sel ? jmp_loc : redir_addr_q;
            redirect_pending_d = 1'b0;
          end else if (!stall) begin
            load      = 1'b1;
            load_ins  = imem_rdata;
            load_addr = pc_q;
            pc_d      = pc_q + 8'd1;
          end else begin
            skid_ins_d  = imem_rdata;
            skid_addr_d = pc_q;
            pc_d        = pc_q + 8'd1;
            state_d     = FULL;
          end
        end else if (pc_mux_sel) begin
          // Address must stay stable until the ack, so remember the target (latest wins).
          redirect_pending_d = 1'b1;
          redir_addr_d       = jmp_loc;
        end
      end

      FULL: begin
        if (pc_mux_sel) begin
          pc_d    = jmp_loc;
          state_d = REQ;
        end else if (!stall) begin
          load      = 1'b1;
          load_ins  = skid_ins_q;
          load_addr = skid_addr_q;
          state_d   = REQ;
        end
      end

      default: begin
        state_d            = IDLE;
        redirect_pending_d = 1'b0;
      end
    endcase

    if (pc_mux_sel) begin
      ins_d       = NOP_WORD;
      ins_valid_d = 1'b0;
    end else if (stall) begin
      ins_d       = ins_q;
      ins_valid_d = ins_valid_q;
    end else if (load) begin
      ins_d       = load_ins;
      cur_addr_d  = load_addr;
      ins_valid_d = 1'b1;
    end else begin
      ins_d       = NOP_WORD;
      ins_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      pc_q               <= RESET_VECTOR;
      ins_q              <= NOP_WORD;
      cur_addr_q         <= RESET_VECTOR;
      ins_valid_q        <= 1'b0;
      redirect_pending_q <= 1'b0;
      redir_addr_q       <= 8'h00;
      skid_ins_q         <= 24'h000000;
      skid_addr_q        <= 8'h00;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q            <= state_d;
      pc_q               <= pc_d;
      ins_q              <= ins_d;
      cur_addr_q         <= cur_addr_d;
      ins_valid_q        <= ins_valid_d;
      redirect_pending_q <= redirect_pending_d;
      redir_addr_q       <= redir_addr_d;
      skid_ins_q         <= skid_ins_d;
      skid_addr_q        <= skid_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: a default-vector instance for the main
// scenarios and a RESET_VECTOR=8'hFE instance that always acks, for the PC wrap.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  jmp_loc;
  logic        pc_mux_sel;
  logic        stall;
  logic        auto_ack;
  logic        m_ack;
  logic [23:0] m_rdata;

  logic        a_req, a_ack, a_valid;
  logic [7:0]  a_addr, a_cur;
  logic [23:0] a_rdata, a_ins;

  logic        b_req, b_ack, b_valid;
  logic [7:0]  b_addr, b_cur;
  logic [23:0] b_rdata, b_ins;

  int checks   = 0;
  int failures = 0;
  logic fetched_20 = 1'b0;

  always #5 clk = ~clk;

  // Memory model: either acks every request immediately with {16'h0, addr}, or is driven by hand.
  assign a_ack   = auto_ack ? a_req : m_ack;
  assign a_rdata = auto_ack ? {16'h0000, a_addr} : m_rdata;
  assign b_ack   = b_req;
  assign b_rdata = {16'h0000, b_addr};

  pc_fetch_unit u_dut (
    .clk             (clk),
    .reset           (reset),
    .jmp_loc         (jmp_loc),
    .pc_mux_sel      (pc_mux_sel),
    .stall           (stall),
    .imem_req        (a_req),
    .imem_addr       (a_addr),
    .imem_ack        (a_ack),
    .imem_rdata      (a_rdata),
    .ins             (a_ins),
    .Current_Address (a_cur),
    .ins_valid       (a_valid)
  );

  pc_fetch_unit #(.RESET_VECTOR(8'hFE)) u_wrap (
    .clk             (clk),
    .reset           (reset),
    .jmp_loc         (8'h00),
    .pc_mux_sel      (1'b0),
    .stall           (1'b0),
    .imem_req        (b_req),
    .imem_addr       (b_addr),
    .imem_ack        (b_ack),
    .imem_rdata      (b_rdata),
    .ins             (b_ins),
    .Current_Address (b_cur),
    .ins_valid       (b_valid)
  );

  always @(negedge clk) begin
    if (reset === 1'b1 && a_req === 1'b1 && a_addr === 8'h20) fetched_20 = 1'b1;
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    jmp_loc    = 8'h00;
    pc_mux_sel = 1'b0;
    stall      = 1'b0;
    auto_ack   = 1'b0;
    m_ack      = 1'b0;
    m_rdata    = 24'h000000;

    step();
    step();
    check("rst_req",   a_req,   0);
    check("rst_addr",  a_addr,  24'h00);
    check("rst_ins",   a_ins,   24'h000000);
    check("rst_cur",   a_cur,   24'h00);
    check("rst_valid", a_valid, 0);
    check("rst_wrap_addr", b_addr, 24'hFE);
    check("rst_wrap_req",  b_req,  0);

    // Linear fetch: first request appears one cycle after reset release.
    reset    = 1'b1;
    auto_ack = 1'b1;
    step();
    check("first_req",   a_req,   1);
    check("first_addr",  a_addr,  24'h00);
    check("first_valid", a_valid, 0);
    check("wrap_first_addr", b_addr, 24'hFE);

    for (int k = 0; k < 6; k++) begin
      logic [7:0] ea, eb, ebi;
      ea  = 8'(k + 1);
      eb  = 8'(8'hFF + k);
      ebi = 8'(8'hFE + k);
      step();
      check("lin_addr",  a_addr,  {16'h0, ea});
      check("lin_ins",   a_ins,   24'(k));
      check("lin_cur",   a_cur,   24'(k));
      check("lin_valid", a_valid, 1);
      check("wrap_addr",  b_addr,  {16'h0, eb});
      check("wrap_ins",   b_ins,   {16'h0, ebi});
      check("wrap_cur",   b_cur,   {16'h0, ebi});
      check("wrap_valid", b_valid, 1);
    end

    // Redirect at Current_Address=05 with the in-flight word acked the same cycle.
    pc_mux_sel = 1'b1;
    jmp_loc    = 8'h40;
    step();
    check("redir_ins",   a_ins,   24'h000000);
    check("redir_valid", a_valid, 0);
    check("redir_addr",  a_addr,  24'h40);
    check("redir_cur",   a_cur,   24'h05);
    pc_mux_sel = 1'b0;
    step();
    check("redir_tgt_ins",   a_ins,   24'h000040);
    check("redir_tgt_cur",   a_cur,   24'h40);
    check("redir_tgt_valid", a_valid, 1);
    check("redir_tgt_next",  a_addr,  24'h41);

    // Redirects while a 3-cycle fetch of 41 is outstanding; latest target wins.
    auto_ack = 1'b0;
    m_ack    = 1'b0;
    step();
    check("pend_addr0",  a_addr,  24'h41);
    check("pend_req0",   a_req,   1);
    check("pend_valid0", a_valid, 0);
    pc_mux_sel = 1'b1;
    jmp_loc    = 8'h20;
    step();
    check("pend_addr1", a_addr, 24'h41);
    jmp_loc = 8'h30;
    step();
    check("pend_addr2",  a_addr,  24'h41);
    check("pend_valid2", a_valid, 0);
    pc_mux_sel = 1'b0;
    m_ack      = 1'b1;
    m_rdata    = 24'hABCDEF;
    step();
    check("pend_discard_ins",   a_ins,   24'h000000);
    check("pend_discard_valid", a_valid, 0);
    check("pend_new_addr",      a_addr,  24'h30);
    m_rdata = 24'h000030;
    step();
    check("pend_tgt_ins",   a_ins,   24'h000030);
    check("pend_tgt_cur",   a_cur,   24'h30);
    check("pend_tgt_valid", a_valid, 1);
    check("pend_tgt_next",  a_addr,  24'h31);

    // Move to 0F, fetch it, then stall while the ack for 10 arrives.
    pc_mux_sel = 1'b1;
    jmp_loc    = 8'h0F;
    m_rdata    = 24'h000031;
    step();
    check("pre_stall_addr", a_addr, 24'h0F);
    pc_mux_sel = 1'b0;
    m_rdata    = 24'h00000F;
    step();
    check("pre_stall_ins",  a_ins,  24'h00000F);
    check("pre_stall_addr2", a_addr, 24'h10);
    stall   = 1'b1;
    m_rdata = 24'h000010;
    step();
    check("stall_req",   a_req,   0);
    check("stall_ins",   a_ins,   24'h00000F);
    check("stall_cur",   a_cur,   24'h0F);
    check("stall_valid", a_valid, 1);
    check("stall_addr",  a_addr,  24'h11);
    m_ack = 1'b0;
    step();
    check("stall_hold_req", a_req, 0);
    check("stall_hold_ins", a_ins, 24'h00000F);
    m_ack   = 1'b1;
    m_rdata = 24'h000BAD;
    step();
    check("full_ack_ignored_req",  a_req,  0);
    check("full_ack_ignored_addr", a_addr, 24'h11);
    check("full_ack_ignored_ins",  a_ins,  24'h00000F);
    check("full_ack_ignored_cur",  a_cur,  24'h0F);
    m_ack = 1'b0;
    step();
    check("stall_last_ins", a_ins, 24'h00000F);
    check("stall_last_req", a_req, 0);
    stall = 1'b0;
    step();
    check("skid_ins",    a_ins,   24'h000010);
    check("skid_cur",    a_cur,   24'h10);
    check("skid_valid",  a_valid, 1);
    check("resume_req",  a_req,   1);
    check("resume_addr", a_addr,  24'h11);

    // Bring a valid instruction up with a request outstanding at 33, then reset between edges.
    pc_mux_sel = 1'b1;
    jmp_loc    = 8'h32;
    m_ack      = 1'b1;
    m_rdata    = 24'h000011;
    step();
    check("pre_rst_addr",  a_addr,  24'h32);
    check("pre_rst_cur",   a_cur,   24'h10);
    check("pre_rst_valid", a_valid, 0);
    pc_mux_sel = 1'b0;
    m_rdata    = 24'h000032;
    step();
    check("pre_rst_ins",   a_ins,   24'h000032);
    check("pre_rst_valid2", a_valid, 1);
    check("pre_rst_addr2", a_addr,  24'h33);
    check("pre_rst_req",   a_req,   1);
    m_ack = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_req",   a_req,   0);
    check("async_rst_valid", a_valid, 0);
    check("async_rst_pc",    a_addr,  24'h00);
    check("async_rst_ins",   a_ins,   24'h000000);
    check("async_rst_cur",   a_cur,   24'h00);

    check("never_fetch_20", fetched_20, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
